// File: rtl/lsu.sv
// Load/store unit: runs one req/ack data-memory transaction per memory-phase visit,
// steering store lanes and aligning/extending load data for write-back.
module lsu #(
  parameter logic [2:0]  MEM_STATE      = 3'd3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] rs2_val,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        fault,
  output logic        should_stall
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} st_e;

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  st_e             st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            ld_q, ld_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     ldata_q, ldata_d;
  logic            fault_q, fault_d;

  logic        start;
  logic        legal;
  logic        tmo;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] rshift;
  logic [31:0] ld_aligned;

  assign start = (state == MEM_STATE) && (is_load || is_store);
  assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Size/sign legality and natural alignment; the unsigned loads are not valid for stores.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~address[0];
      3'b010:  legal = (address[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~address[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata = rs2_val;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_val[7:0]}};
        st_wstrb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_val[15:0]}};
        st_wstrb = 4'b0011 << address[1:0];
      end
      default: begin
        st_wdata = rs2_val;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign rshift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_aligned = mem_rdata;
    case (f3_q)
      3'b000:  ld_aligned = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ld_aligned = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  ld_aligned = {24'b0, rshift[7:0]};
      3'b101:  ld_aligned = {16'b0, rshift[15:0]};
      default: ld_aligned = mem_rdata;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ld_d    = ld_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ldata_d = ldata_q;
    fault_d = fault_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          fault_d = ~legal;
          if (legal) begin
            st_d    = StReq;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {address[31:2], 2'b00};
            wdata_d = is_store ? st_wdata : 32'b0;
            wstrb_d = is_store ? st_wstrb : 4'b0;
            cnt_d   = '0;
            f3_d    = funct3;
            off_d   = address[1:0];
            ld_d    = ~is_store;
          end else begin
            st_d = StDone;
          end
        end
      end
      StReq: begin
        if (mem_ack || tmo) begin
          st_d    = StDone;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0;
          if (mem_ack) begin
            if (ld_q) ldata_d = ld_aligned;
          end else begin
            fault_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (state != MEM_STATE) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      ld_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      wstrb_q <= 4'b0;
      ldata_q <= 32'b0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ld_q    <= ld_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ldata_q <= ldata_d;
      fault_q <= fault_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign load_data    = ldata_q;
  assign fault        = fault_q;
  assign should_stall = ((st_q == StIdle) && start) || (st_q == StReq);

endmodule
